// File: rtl/random_engine_dpath_if.sv
// Seed-load and random-value handshake bundle for random_engine_dpath.
// master is the datapath side; slave is the controller/consumer side.
interface random_engine_dpath_if #(
  parameter int unsigned nbits = 16
);
  logic             seed_val;
  logic [nbits-1:0] seed;
  logic             seed_rdy;
  logic             rand_val;
  logic [nbits-1:0] rand_msg;
  logic             rand_rdy;

  modport master (
    input  seed_val, seed, rand_rdy,
    output seed_rdy, rand_val, rand_msg
  );

  modport slave (
    output seed_val, seed, rand_rdy,
    input  seed_rdy, rand_val, rand_msg
  );
endinterface

// File: rtl/random_engine_dpath.sv
// Galois LFSR stepped on lfsr_en, feeding a one-entry val/rdy output buffer,
// with seed loading and a running count of completed output handshakes.
module random_engine_dpath #(
  parameter int unsigned      nbits      = 16,
  parameter logic [nbits-1:0] taps       = 16'hB400,
  parameter logic [nbits-1:0] reset_seed = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  random_engine_dpath_if.master        io,
  input  logic                         lfsr_en,
  output logic                         stall,
  output logic [31:0]                  count
);

  logic [nbits-1:0] s_q, s_d;
  logic [nbits-1:0] buf_q, buf_d;
  logic             v_q, v_d;
  logic [31:0]      count_q, count_d;

  logic             xfer;
  logic             room;
  logic             step;
  logic [nbits-1:0] s_next;

  always_comb begin
    xfer   = v_q & io.rand_rdy;
    room   = ~v_q | io.rand_rdy;
    step   = lfsr_en & ~io.seed_val & room;
    stall  = lfsr_en & ~io.seed_val & ~room;
    s_next = (s_q >> 1) ^ (s_q[0] ? taps : '0);

    s_d     = s_q;
    buf_d   = buf_q;
    v_d     = v_q;
    count_d = count_q + {31'b0, xfer};

    // A seed load drops the held value, but a same-cycle handshake still counts.
    if (io.seed_val) begin
      s_d = (io.seed == '0) ? reset_seed : io.seed;
      v_d = 1'b0;
    end else if (step) begin
      s_d   = s_next;
      buf_d = s_next;
      v_d   = 1'b1;
    end else if (xfer) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= reset_seed;
      buf_q   <= '0;
      v_q     <= 1'b0;
      count_q <= '0;
    end else begin
      s_q     <= s_d;
      buf_q   <= buf_d;
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  assign io.seed_rdy = 1'b1;
  assign io.rand_val = v_q;
  assign io.rand_msg = buf_q;
  assign count       = count_q;

endmodule

// File: tb/tb_random_engine_dpath.sv
// Directed bench for random_engine_dpath: a transaction-level model checked
// every cycle, plus hand-computed literal expectations along the way.
module tb_random_engine_dpath;

  logic        clk = 1'b0;
  logic        rst;
  logic        lfsr_en;
  logic        stall;
  logic [31:0] count;

  random_engine_dpath_if #(.nbits(16)) bus ();

  random_engine_dpath #(
    .nbits      (16),
    .taps       (16'hB400),
    .reset_seed (16'hACE1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (bus.master),
    .lfsr_en (lfsr_en),
    .stall   (stall),
    .count   (count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Model: the LFSR state, whether an undelivered value is pending, and the tally.
  logic [15:0] m_state;
  logic [15:0] m_out;
  logic        m_pending;
  int unsigned m_delivered;

  always @(posedge clk) begin
    if (rst) begin
      m_state     = 16'hACE1;
      m_out       = 16'h0000;
      m_pending   = 1'b0;
      m_delivered = 0;
    end else begin
      logic taken;
      taken = m_pending && bus.rand_rdy;
      if (taken) m_delivered = m_delivered + 1;
      if (bus.seed_val) begin
        m_state   = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
        m_pending = 1'b0;
      end else if (lfsr_en && (!m_pending || taken)) begin
        m_state   = lfsr_next(m_state);
        m_out     = m_state;
        m_pending = 1'b1;
      end else if (taken) begin
        m_pending = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("rand_val", {31'b0, bus.rand_val}, {31'b0, m_pending});
      chk("rand_msg", {16'b0, bus.rand_msg}, {16'b0, m_out});
      chk("count",    count, m_delivered);
      chk("stall",    {31'b0, stall},
          {31'b0, lfsr_en & ~bus.seed_val & m_pending & ~bus.rand_rdy});
      chk("seed_rdy", {31'b0, bus.seed_rdy}, 32'd1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; lfsr_en = 1'b0;
    bus.seed_val = 1'b0; bus.seed = 16'h0000; bus.rand_rdy = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    check_en = 1'b1;
    chk("reset_val",   {31'b0, bus.rand_val}, 32'd0);
    chk("reset_msg",   {16'b0, bus.rand_msg}, 32'h0);
    chk("reset_count", count, 32'd0);

    // Free-running steps with the consumer always ready.
    lfsr_en = 1'b1; bus.rand_rdy = 1'b1;
    cyc(); chk("seq0", {16'b0, bus.rand_msg}, 32'hE270);
    cyc(); chk("seq1", {16'b0, bus.rand_msg}, 32'h7138);
    cyc(); chk("seq2", {16'b0, bus.rand_msg}, 32'h389C);
    lfsr_en = 1'b0;
    cyc(); chk("seq_count", count, 32'd3);
    chk("seq_drained", {31'b0, bus.rand_val}, 32'd0);

    // Seed 0001 steps to B400.
    bus.seed_val = 1'b1; bus.seed = 16'h0001;
    cyc();
    bus.seed_val = 1'b0; lfsr_en = 1'b1;
    cyc(); chk("seed1_msg", {16'b0, bus.rand_msg}, 32'hB400);
    chk("seed1_val", {31'b0, bus.rand_val}, 32'd1);
    lfsr_en = 1'b0;
    cyc(); chk("seed1_gone", {31'b0, bus.rand_val}, 32'd0);

    // A zero seed falls back to the reset seed.
    bus.seed_val = 1'b1; bus.seed = 16'h0000;
    cyc();
    bus.seed_val = 1'b0; lfsr_en = 1'b1;
    cyc(); chk("seed0_msg", {16'b0, bus.rand_msg}, 32'hE270);
    lfsr_en = 1'b0;
    cyc();

    // Backpressure: value held, stall raised, nothing skipped on release.
    rst = 1'b1; cyc(); rst = 1'b0;
    lfsr_en = 1'b1; bus.rand_rdy = 1'b1;
    cyc();
    bus.rand_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_stall", {31'b0, stall}, 32'd1);
      chk("bp_hold",  {16'b0, bus.rand_msg}, 32'hE270);
      cyc();
    end
    bus.rand_rdy = 1'b1;
    #1 chk("bp_unstall", {31'b0, stall}, 32'd0);
    cyc(); chk("bp_next", {16'b0, bus.rand_msg}, 32'h7138);
    chk("bp_count1", count, 32'd1);
    cyc(); chk("bp_next2", {16'b0, bus.rand_msg}, 32'h389C);
    lfsr_en = 1'b0;
    cyc(); chk("bp_count3", count, 32'd3);

    // Seed and step together with a full buffer being drained.
    lfsr_en = 1'b1; bus.rand_rdy = 1'b0;
    cyc(); chk("full_msg", {16'b0, bus.rand_msg}, 32'h1C4E);
    bus.seed_val = 1'b1; bus.seed = 16'h1234; bus.rand_rdy = 1'b1;
    #1 chk("seed_nostall", {31'b0, stall}, 32'd0);
    cyc();
    chk("seedwin_val",   {31'b0, bus.rand_val}, 32'd0);
    chk("seedwin_count", count, 32'd4);
    bus.seed_val = 1'b0;
    cyc(); chk("seedwin_next", {16'b0, bus.rand_msg}, 32'h091A);
    lfsr_en = 1'b0;
    cyc(); chk("seedwin_count2", count, 32'd5);

    // Reset in the middle of continuous stepping.
    lfsr_en = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_val",   {31'b0, bus.rand_val}, 32'd0);
    chk("mid_rst_count", count, 32'd0);
    rst = 1'b0;
    cyc(); chk("mid_rst_first", {16'b0, bus.rand_msg}, 32'hE270);
    lfsr_en = 1'b0;
    cyc(); cyc();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/random_engine_dpath.md
# random_engine_dpath

Datapath stage directly downstream of the random engine controller. It holds a Galois LFSR, advances it one step per cycle when the controller asserts `lfsr_en`, and presents each new value through a one-entry output buffer with a val/rdy handshake. It also accepts seed loads and keeps a running count of delivered values.

## Interface
- nbits, 16: LFSR and output width (≥ 2).
- taps, 16'hB400: Galois feedback mask, nbits wide; the default is maximal-length for nbits=16, period 65535.
- reset_seed, 16'hACE1: LFSR value after reset and on a zero-seed load; must be non-zero.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_val  in  1  seed load request.
- seed  in  nbits  seed value.
- seed_rdy  out  1  constant 1; a seed load is accepted every cycle.
- lfsr_en  in  1  step request from the controller.
- rand_val  out  1  the output buffer holds an undelivered value.
- rand_msg  out  nbits  output buffer contents.
- rand_rdy  in  1  downstream accepts rand_msg.
- stall  out  1  combinational; lfsr_en is high but no step is possible because the buffer is full and not draining.
- count  out  32  number of completed output handshakes; wraps modulo 2^32.

## Operation
- Registers:
  - LFSR state `s` (nbits).
  - Output buffer `buf` (nbits) with its valid flag `v`.
  - Handshake counter `count` (32).
- Step function: next(s) = (s >> 1) ^ (s[0] ? taps : 0).
- Handshake: `xfer` = rand_val & rand_rdy.
- Room in the buffer: `room` = ~v | rand_rdy.
- Step condition: `step` = lfsr_en & ~seed_val & room.
- stall = lfsr_en & ~seed_val & ~room.
- Priority of updates, highest first: rst, then seed load, then step.
- Seed load (seed_val high):
  - s ← seed, or reset_seed if seed == 0. The LFSR never enters the all-zero lock-up state.
  - v ← 0. Any value still held is discarded, but a handshake in the same cycle still completes and is counted.
  - lfsr_en is ignored that cycle.
- Step:
  - s ← next(s), buf ← next(s), v ← 1.
  - buf always equals s after a step.
- No step, no seed load: if xfer then v ← 0; buf and s hold.
- count increments on every xfer, including in seed-load cycles. A seed load does not clear count.
- Stalled cycles do not advance s; no value is skipped or duplicated.
- Arithmetic: all values are unsigned. count wraps from FFFF_FFFF to 0.

## Timing
- Reset values, applied on the edge where rst is high:
  - s = reset_seed.
  - rand_val = 0, rand_msg = 0, count = 0.
  - stall follows its inputs combinationally.
- Seed latency: seed presented in cycle t becomes the LFSR state at t+1. The first lfsr_en after that produces next(seed).
- Step latency: lfsr_en in cycle t with room gives rand_val = 1 and rand_msg = next(s) at t+1.
- Throughput: 1 value per cycle while lfsr_en and rand_rdy are held high.
- Backpressure:
  - rand_msg is stable while rand_val & ~rand_rdy.
  - Once rand_val rises, it falls only after a handshake or a seed load.
- rst asserted mid-stream overrides seed_val and lfsr_en. All state returns to reset values on the next edge.
- Simultaneous seed_val and lfsr_en: the seed wins, no step occurs, and stall = 0.

## Test plan
- Reset, then lfsr_en = 1 for 3 cycles with rand_rdy = 1 → rand_msg is E270, 7138, 389C on consecutive cycles; count = 3.
- seed_val with seed = 0001, then one step → rand_msg = (0000 ^ B400) = B400; rand_val = 1 for one cycle.
- seed_val with seed = 0000 → state = ACE1; the next step gives E270.
- After reset, one step, then rand_rdy = 0 with lfsr_en held for 4 cycles → rand_msg holds E270 and stall = 1. Raising rand_rdy yields 7138 the next cycle; no value is skipped and count increments by one per handshake.
- seed_val and lfsr_en together while the buffer is full and rand_rdy = 1 → the handshake is counted, rand_val = 0 next cycle, and state = seed.
- rst during continuous stepping → next cycle rand_val = 0 and count = 0. The first step after reset gives E270.
